sram_rw_port_arbiter: RTL and testbench
=======================================

Name: sram_rw_port_arbiter

Overview:
- Shares the single read/write port (port 0) of the 32x512 OpenRAM SRAM macro between two requesters.
  - Requester A: instruction/boot side.
  - Requester B: data load/store side.
- Round-robin arbitration; read data returned one cycle after grant.
- Built-in clear engine sequences a full-array fill (CLEAR_VALUE to all words) on command.
- Sits between the core's memory interfaces and the SRAM macro; the macro's read-only port 1 is not handled here.

Parameters:
- ADDR_WIDTH, 9, word address width (RAM depth = 1<<ADDR_WIDTH).
- DATA_WIDTH, 32, word width.
- NUM_WMASKS, 4, byte write-enable count (DATA_WIDTH/8).
- CLEAR_VALUE, 32'h00000000, word written by the clear engine.

Ports:
- clk  in  1  single clock; also drives the SRAM clk0.
- rst_n  in  1  synchronous active-low reset.
- a_req  in  1  A access request; held with its fields stable until a_gnt.
- a_we  in  1  1=write, 0=read.
- a_wmask  in  NUM_WMASKS  byte enables for writes.
- a_addr  in  ADDR_WIDTH  word address.
- a_wdata  in  DATA_WIDTH  write data.
- a_gnt  out  1  access accepted this cycle (combinational).
- a_rvalid  out  1  read data valid (registered).
- a_rdata  out  DATA_WIDTH  read data; 0 when a_rvalid=0.
- b_req, b_we, b_wmask, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical to the A ports, for B.
- clr_start  in  1  one-cycle pulse; starts a full-array clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- sram_csb0  out  1  SRAM chip select, active low.
- sram_web0  out  1  SRAM write enable, active low.
- sram_wmask0  out  NUM_WMASKS  SRAM byte mask.
- sram_addr0  out  ADDR_WIDTH  SRAM address.
- sram_din0  out  DATA_WIDTH  SRAM write data.
- sram_dout0  in  DATA_WIDTH  SRAM read data; valid from the negedge after the sampling posedge.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, rr_ptr=A-priority, clear counter=0.
  - a_rvalid=b_rvalid=0, clr_busy=0, clr_done=0.
  - While rst_n=0: a_gnt=b_gnt=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
- SRAM-side outputs are combinational from the grant or clear state; the macro registers them at the next posedge.
- FSM states: IDLE and CLEAR.
- IDLE arbitration:
  - Only A requests -> a_gnt=1. Only B requests -> b_gnt=1.
  - Both request -> grant the side indicated by rr_ptr.
  - On any grant, rr_ptr moves to point at the other side.
  - At most one gnt per cycle.
  - Granted side drives: sram_csb0=0, sram_web0=~we, sram_addr0=addr, sram_din0=wdata, sram_wmask0 = we ? wmask : 0.
  - No grant -> sram_csb0=1, other SRAM outputs 0.
- Read latency:
  - Read granted in cycle N -> x_rvalid=1 for exactly cycle N+1.
  - In cycle N+1, x_rdata=sram_dout0.
  - Back-to-back reads on consecutive cycles are allowed: full throughput, one access per cycle.
- Writes:
  - Complete on grant; no response signal.
  - Write with wmask=0 is still issued (csb0=0, web0=0, mask 0); memory is unchanged.
- Clear engine:
  - clr_start is sampled in IDLE. Normal grants are still allowed in the same cycle N.
  - From cycle N+1, state=CLEAR, clr_busy=1.
  - CLEAR issues one write per cycle: addr = counter 0..(1<<ADDR_WIDTH)-1, wmask all ones, din=CLEAR_VALUE.
  - a_gnt=b_gnt=0 throughout CLEAR; requests stay pending.
  - After the write to the last address (cycle N+512 at default depth), next cycle: state=IDLE, clr_busy=0, clr_done=1 for one cycle, counter=0.
  - Arbitration resumes in that same cycle.
- clr_start while clr_busy=1: ignored.
- An rvalid for a read granted in cycle N is still delivered in N+1 even though CLEAR has begun.
- Reset mid-clear: abort immediately; no clr_done. Memory contents are partially cleared; no recovery is attempted.
- Counter wrap: the counter is ADDR_WIDTH+1 bits wide; the termination test is on all-ones of the low ADDR_WIDTH bits.

Test Plan:
- Reset, then A reads addr 5 (preloaded 32'hfd010113) -> cycle N: a_gnt=1, sram_csb0=0, web0=1, addr0=5; cycle N+1: a_rvalid=1, a_rdata=32'hfd010113; b_rvalid=0.
- A and B both request every cycle for 4 cycles -> grants B,A,B,A (rr_ptr alternates after the first A-priority grant); each read's rvalid on the matching side exactly one cycle later.
- B writes 32'hAABBCCDD to addr 10 with wmask 4'b0101, then A reads addr 10 (prior value 0) -> a_rdata=32'h00BB00DD.
- clr_start pulse with a_req held -> clr_busy=1 for 512 cycles, a_gnt=0 during them, sram_addr0 steps 0..511; clr_done pulses once; a_gnt=1 in the clr_done cycle; reads of addr 0, 277 and 511 return 0.
- Second clr_start mid-clear at counter 100 -> ignored; clr_done asserts once at the original time.
- rst_n=0 for one cycle at counter 200 -> clr_busy=0, sram_csb0=1, no clr_done; addr 300 retains its pre-clear value.

Source files
------------

// File: rtl/sram_rw_port_arbiter.sv
`default_nettype none
// ============================================================================
// sram_rw_port_arbiter: round-robin A/B arbiter and array-clear engine for SRAM port 0
// Revision: 1.0
// ============================================================================
module sram_rw_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  rr_ptr;     // 0: A wins a tie, 1: B wins a tie
  logic [ADDR_WIDTH:0]   clr_cnt;
  logic                  clr_last;

  // Termination looks only at the low bits so the extra counter bit never matters.
  assign clr_last = &clr_cnt[ADDR_WIDTH-1:0];
  assign clr_busy = rst_n && (state == CLEAR);
  assign a_rdata  = a_rvalid ? sram_dout0 : '0;
  assign b_rdata  = b_rvalid ? sram_dout0 : '0;

  always_comb begin
    state_nxt   = state;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (a_req && (!b_req || !rr_ptr)) begin
            a_gnt = 1'b1;
          end else if (b_req) begin
            b_gnt = 1'b1;
          end
          if (a_gnt) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~a_we;
            sram_wmask0 = a_we ? a_wmask : '0;
            sram_addr0  = a_addr;
            sram_din0   = a_wdata;
          end else if (b_gnt) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~b_we;
            sram_wmask0 = b_we ? b_wmask : '0;
            sram_addr0  = b_addr;
            sram_din0   = b_wdata;
          end
          if (clr_start) begin
            state_nxt = CLEAR;
          end
        end
        CLEAR: begin
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_wmask0 = '1;
          sram_addr0  = clr_cnt[ADDR_WIDTH-1:0];
          sram_din0   = CLEAR_VALUE;
          if (clr_last) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      clr_cnt  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      clr_done <= (state == CLEAR) && clr_last;
      if (a_gnt) begin
        rr_ptr <= 1'b1;
      end else if (b_gnt) begin
        rr_ptr <= 1'b0;
      end
      if (state == CLEAR) begin
        clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_rw_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_rw_port_arbiter: directed + random checks against a memory-array reference model
// Revision: 1.0
// ============================================================================
module tb_sram_rw_port_arbiter;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int NW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] CLR_VAL = 32'h00000000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we, clr_start;
  logic [NW-1:0] a_wmask, b_wmask;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, clr_busy, clr_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          sram_csb0, sram_web0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0 = '0;

  always #5 clk = ~clk;

  sram_rw_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW), .CLEAR_VALUE(CLR_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  function automatic logic [DW-1:0] init_val(int a);
    if (a == 5)  return 32'hfd010113;
    if (a == 10) return 32'h00000000;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Behavioural model of the macro's port 0: unwritten words read their preload value.
  logic [DW-1:0] sram_mem [DEPTH];
  bit            sram_wr  [DEPTH];
  always @(posedge clk) begin : sram_model
    logic [DW-1:0] w;
    if (!sram_csb0) begin
      w = sram_wr[sram_addr0] ? sram_mem[sram_addr0] : init_val(int'(sram_addr0));
      if (!sram_web0) begin
        for (int k = 0; k < NW; k++)
          if (sram_wmask0[k]) w[8*k +: 8] = sram_din0[8*k +: 8];
        sram_mem[sram_addr0] <= w;
        sram_wr[sram_addr0]  <= 1'b1;
      end else begin
        sram_dout0 <= w;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: expected memory image, tie-break preference and clear progress.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            b_first, clearing;
  int            clr_cnt;
  bit            exp_arv, exp_brv, exp_done;
  logic [DW-1:0] exp_ard, exp_brd;
  bit            ga, gb;
  bit            obs_agnt, obs_bgnt, obs_done, obs_busy;
  logic [DW-1:0] obs_ard;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [NW-1:0] m);
    logic [DW-1:0] r = old;
    for (int k = 0; k < NW; k++) if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // One clock cycle: inputs are already applied; check at negedge, advance model, return after posedge.
  task automatic run_cycle();
    bit            e_csb, e_web;
    logic [NW-1:0] e_mask;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    @(negedge clk);
    obs_agnt = a_gnt; obs_bgnt = b_gnt; obs_done = clr_done; obs_busy = clr_busy; obs_ard = a_rdata;
    chk("a_rvalid", a_rvalid, exp_arv);
    chk("a_rdata", a_rdata, exp_ard);
    chk("b_rvalid", b_rvalid, exp_brv);
    chk("b_rdata", b_rdata, exp_brd);
    chk("clr_done", clr_done, exp_done);
    chk("clr_busy", clr_busy, clearing && rst_n);
    ga = 0; gb = 0; e_csb = 1; e_web = 1; e_mask = '0; e_addr = '0; e_din = '0;
    if (rst_n && clearing) begin
      e_csb = 0; e_web = 0; e_mask = '1; e_addr = AW'(clr_cnt); e_din = CLR_VAL;
    end else if (rst_n) begin
      if (a_req && b_req) begin ga = !b_first; gb = b_first; end
      else begin ga = a_req; gb = b_req; end
      if (ga) begin
        e_csb = 0; e_web = !a_we; e_addr = a_addr; e_din = a_wdata; e_mask = a_we ? a_wmask : '0;
      end
      if (gb) begin
        e_csb = 0; e_web = !b_we; e_addr = b_addr; e_din = b_wdata; e_mask = b_we ? b_wmask : '0;
      end
    end
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    chk("sram_csb0", sram_csb0, e_csb);
    chk("sram_web0", sram_web0, e_web);
    chk("sram_wmask0", sram_wmask0, e_mask);
    chk("sram_addr0", sram_addr0, e_addr);
    chk("sram_din0", sram_din0, e_din);
    exp_arv = 0; exp_brv = 0; exp_ard = '0; exp_brd = '0; exp_done = 0;
    if (!rst_n) begin
      clearing = 0; clr_cnt = 0; b_first = 0;
    end else if (clearing) begin
      ref_mem[clr_cnt] = CLR_VAL;
      if (clr_cnt == DEPTH - 1) begin clearing = 0; clr_cnt = 0; exp_done = 1; end
      else clr_cnt++;
    end else begin
      if (ga) begin
        if (a_we) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_wmask);
        else begin exp_arv = 1; exp_ard = ref_mem[a_addr]; end
        b_first = 1;
      end
      if (gb) begin
        if (b_we) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wdata, b_wmask);
        else begin exp_brv = 1; exp_brd = ref_mem[b_addr]; end
        b_first = 0;
      end
      if (clr_start) begin clearing = 1; clr_cnt = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic a_read(logic [AW-1:0] addr);
    a_req = 1; a_we = 0; a_addr = addr;
    run_cycle();
    a_req = 0;
    run_cycle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_cnt;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    b_first = 0; clearing = 0; clr_cnt = 0;
    exp_arv = 0; exp_brv = 0; exp_done = 0; exp_ard = '0; exp_brd = '0;
    rst_n = 0; clr_start = 0;
    a_req = 1; a_we = 0; a_wmask = '0; a_addr = 5; a_wdata = '0;
    b_req = 1; b_we = 1; b_wmask = '1; b_addr = 7; b_wdata = 32'h12345678;
    @(posedge clk); #1;
    repeat (2) run_cycle();            // requests must be blocked while in reset
    rst_n = 1; a_req = 0; b_req = 0;
    run_cycle();

    a_read(5);
    chk("t1_rdata", obs_ard, 32'hfd010113);

    for (int i = 0; i < 4; i++) begin
      a_req = 1; a_we = 0; a_addr = AW'(20 + i);
      b_req = 1; b_we = 0; b_addr = AW'(40 + i);
      run_cycle();
      chk("rr_seq_b", obs_bgnt, (i % 2 == 0));
    end
    a_req = 0; b_req = 0;
    run_cycle();

    b_req = 1; b_we = 1; b_wmask = 4'b0101; b_addr = 10; b_wdata = 32'hAABBCCDD;
    run_cycle();
    b_req = 0;
    a_read(10);
    chk("wmask_rd", obs_ard, 32'h00BB00DD);

    for (int c = 0; c < 400; c++) begin
      if (!a_req || ga) begin
        a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
        a_wmask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
        a_addr = AW'($urandom_range(0, 31)); a_wdata = $urandom;
      end
      if (!b_req || gb) begin
        b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
        b_wmask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
        b_addr = AW'($urandom_range(0, 31)); b_wdata = $urandom;
      end
      run_cycle();
    end
    a_req = 0; b_req = 0;
    run_cycle();

    // Clear with A held; a stray clr_start at counter 100 must be ignored.
    a_req = 1; a_we = 0; a_addr = 0; clr_start = 1;
    run_cycle();
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 530; c++) begin
      clr_start = clearing && (clr_cnt == 100);
      run_cycle();
      busy_cnt += int'(obs_busy);
      done_cnt += int'(obs_done);
      if (obs_done) begin
        chk("gnt_in_done", obs_agnt, 1);
        a_req = 0;
      end
    end
    clr_start = 0;
    chk("busy_cycles", busy_cnt, 512);
    chk("done_pulses", done_cnt, 1);
    a_read(277);
    chk("clr_rd_277", obs_ard, 32'h0);
    a_read(511);
    chk("clr_rd_511", obs_ard, 32'h0);

    // Reset in the middle of a second clear.
    b_req = 1; b_we = 1; b_wmask = '1; b_addr = 300; b_wdata = 32'h13572468;
    run_cycle();
    b_req = 0; clr_start = 1;
    run_cycle();
    clr_start = 0;
    for (int c = 0; c < 300 && clr_cnt != 200; c++) run_cycle();
    rst_n = 0;
    run_cycle();
    chk("rst_busy", obs_busy, 0);
    rst_n = 1;
    done_cnt = 0;
    for (int c = 0; c < 520; c++) begin
      run_cycle();
      done_cnt += int'(obs_done);
    end
    chk("no_done_after_rst", done_cnt, 0);
    a_read(300);
    chk("rd_300_kept", obs_ard, 32'h13572468);
    a_read(150);
    chk("rd_150_cleared", obs_ard, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
